// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pwm_pkg                                                |
// | Brief   : Shared types and defaults for the multi-channel PWM.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int unsigned C_CHANNELS_DEFAULT   = 4;
  localparam int unsigned C_WIDTH_DEFAULT      = 8;
  localparam int unsigned C_PRESCALE_W_DEFAULT = 16;

  // Duty array for the default build; the top derives its own from its parameters.
  typedef logic [C_CHANNELS_DEFAULT-1:0][C_WIDTH_DEFAULT-1:0] pwm_duty_t;

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pwm_timebase                                           |
// | Brief   : Prescaler plus edge/center up-down counter with        |
// |           period-boundary detection.                             |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [WIDTH-1:0]      i_period,
  input  pwm_mode_e             i_mode,
  output logic [WIDTH-1:0]      o_cnt,
  output logic                  o_boundary
);

  logic [PRESCALE_W-1:0] r_pre;
  logic [WIDTH-1:0]      r_cnt;
  pwm_dir_e              r_dir;

  logic                  w_tick;
  logic                  w_wrap;
  logic [WIDTH-1:0]      w_cnt_nxt;
  pwm_dir_e              w_dir_nxt;

  assign w_tick = i_en && (r_pre == i_prescale);

  // w_wrap marks the step that ends a period; the counter then restarts at 0 going up.
  always_comb begin
    w_cnt_nxt = r_cnt + 1'b1;
    w_dir_nxt = r_dir;
    w_wrap    = 1'b0;
    if (i_mode == PWM_EDGE) begin
      w_wrap    = (r_cnt >= i_period);
      w_dir_nxt = DIR_UP;
    end else if (r_dir == DIR_UP) begin
      if (r_cnt >= i_period) begin
        w_cnt_nxt = (i_period == '0) ? '0 : i_period - 1'b1;
        w_dir_nxt = DIR_DOWN;
        w_wrap    = (i_period <= WIDTH'(1));
      end
    end else begin
      w_cnt_nxt = r_cnt - 1'b1;
      w_wrap    = (r_cnt <= WIDTH'(1));
    end
  end

  assign o_boundary = w_tick && w_wrap;
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_pre <= '0;
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      if (i_en) begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
      end
      if (w_tick) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_dir <= DIR_UP;
        end else begin
          r_cnt <= w_cnt_nxt;
          r_dir <= w_dir_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pwm_multi                                              |
// | Brief   : Multi-channel PWM with double-buffered period, mode    |
// |           and duty applied at period boundaries.                 |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = C_CHANNELS_DEFAULT,
  parameter int WIDTH      = C_WIDTH_DEFAULT,
  parameter int PRESCALE_W = C_PRESCALE_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            en,
  input  logic [PRESCALE_W-1:0]           prescale,
  input  logic [WIDTH-1:0]                period,
  input  logic                            mode,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  duty,
  input  logic                            load,
  output logic [CHANNELS-1:0]             out,
  output logic                            period_done,
  output logic                            busy
);

  logic [WIDTH-1:0]                r_sh_period;
  pwm_mode_e                       r_sh_mode;
  logic [CHANNELS-1:0][WIDTH-1:0]  r_sh_duty;
  logic [WIDTH-1:0]                r_act_period;
  pwm_mode_e                       r_act_mode;
  logic [CHANNELS-1:0][WIDTH-1:0]  r_act_duty;

  logic [WIDTH-1:0]                w_cnt;
  logic                            w_boundary;
  logic [CHANNELS-1:0]             w_cmp;

  pwm_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk        (clk),
    .clr        (clr),
    .i_en       (en),
    .i_prescale (prescale),
    .i_period   (r_act_period),
    .i_mode     (r_act_mode),
    .o_cnt      (w_cnt),
    .o_boundary (w_boundary)
  );

  // Shadow is kept in step with active on a coincident load so a later boundary cannot restore stale values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sh_period  <= '0;
      r_sh_mode    <= PWM_EDGE;
      r_sh_duty    <= '0;
      r_act_period <= '0;
      r_act_mode   <= PWM_EDGE;
      r_act_duty   <= '0;
      busy         <= 1'b0;
      period_done  <= 1'b0;
    end else begin
      period_done <= w_boundary;
      if (w_boundary && load) begin
        r_act_period <= period;
        r_act_mode   <= pwm_mode_e'(mode);
        r_act_duty   <= duty;
        r_sh_period  <= period;
        r_sh_mode    <= pwm_mode_e'(mode);
        r_sh_duty    <= duty;
        busy         <= 1'b0;
      end else if (w_boundary) begin
        if (busy) begin
          r_act_period <= r_sh_period;
          r_act_mode   <= r_sh_mode;
          r_act_duty   <= r_sh_duty;
        end
        busy <= 1'b0;
      end else if (load) begin
        r_sh_period <= period;
        r_sh_mode   <= pwm_mode_e'(mode);
        r_sh_duty   <= duty;
        busy        <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_cmp[i] = (r_act_duty[i] > w_cnt);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out <= '0;
    end else begin
      out <= en ? w_cmp : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_pwm_multi                                           |
// | Brief   : Scoreboard bench for pwm_multi with a period-position  |
// |           reference model and randomized stimulus.               |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic          load;
  logic          mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  pwm_duty_t     duty;
  logic [CH-1:0] out;
  logic          period_done;
  logic          busy;

  always #5 clk = ~clk;

  pwm_multi #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .mode        (mode),
    .duty        (duty),
    .load        (load),
    .out         (out),
    .period_done (period_done),
    .busy        (busy)
  );

  typedef struct packed {
    logic [CH-1:0] out;
    logic          pd;
    logic          busy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: position within the period (0..len-1) rather than a direction register.
  int m_pre, m_pos, m_per, s_per;
  bit m_center, s_center, m_busy;
  int m_duty[CH];
  int s_duty[CH];

  always @(posedge clk) begin : model
    exp_t e;
    int   cnt, len;
    bit   tick, bnd;
    e = '0;
    if (clr) begin
      m_pre = 0; m_pos = 0; m_per = 0; s_per = 0;
      m_center = 0; s_center = 0; m_busy = 0;
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 0;
        s_duty[i] = 0;
      end
    end else begin
      cnt = (m_center && m_pos > m_per) ? 2 * m_per - m_pos : m_pos;
      for (int i = 0; i < CH; i++) e.out[i] = en && (m_duty[i] > cnt);
      tick = en && (m_pre == int'(prescale));
      len  = m_center ? 2 * m_per : m_per + 1;
      if (len < 1) len = 1;
      bnd  = tick && (m_pos + 1 == len);
      if (en) m_pre = tick ? 0 : ((m_pre + 1) & 16'hFFFF);
      if (tick) m_pos = bnd ? 0 : m_pos + 1;
      e.pd = bnd;
      if (bnd && load) begin
        m_per = int'(period); m_center = mode; s_per = m_per; s_center = m_center;
        for (int i = 0; i < CH; i++) begin
          m_duty[i] = int'(duty[i]);
          s_duty[i] = m_duty[i];
        end
        m_busy = 0;
      end else if (bnd) begin
        if (m_busy) begin
          m_per = s_per; m_center = s_center;
          for (int i = 0; i < CH; i++) m_duty[i] = s_duty[i];
        end
        m_busy = 0;
      end else if (load) begin
        s_per = int'(period); s_center = mode;
        for (int i = 0; i < CH; i++) s_duty[i] = int'(duty[i]);
        m_busy = 1;
      end
      e.busy = m_busy;
    end
    q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out", (^out === 1'bx) ? -1 : int'(out), int'(e.out));
      chk("period_done", (period_done === 1'bx) ? -1 : int'(period_done), int'(e.pd));
      chk("busy", (busy === 1'bx) ? -1 : int'(busy), int'(e.busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0;
    prescale = '0; period = '0; duty = '0;
    cyc(2);
    clr = 1'b0; en = 1'b1;

    // Edge mode, mixed duties; the first load lands on a boundary (active period 0).
    period = 8'd9; duty = {8'd255, 8'd10, 8'd3, 8'd0};
    do_load();
    cyc(40);

    // Prescaled ticks
    prescale = 16'd4; period = 8'd3; duty[1] = 8'd2;
    do_load();
    cyc(60);

    // Center mode from a clean prescaler
    do_clr();
    prescale = '0; period = 8'd4; mode = 1'b1; duty = {8'd0, 8'd5, 8'd1, 8'd2};
    do_load();
    cyc(40);

    // Mid-period duty change stays pending until the boundary
    mode = 1'b0; period = 8'd9; duty[0] = 8'd3;
    do_load();
    cyc(25);
    duty[0] = 8'd7;
    do_load();
    cyc(30);

    // Enable drop mid-period
    cyc(4);
    en = 1'b0;
    cyc(7);
    en = 1'b1;
    cyc(30);

    // Reset with a load pending
    prescale = 16'd20;
    duty = {8'd9, 8'd9, 8'd9, 8'd9};
    do_load();
    cyc(3);
    do_clr();
    cyc(30);

    for (int it = 0; it < 40; it++) begin
      int n;
      if (it % 8 == 0) begin
        do_clr();
        prescale = PW'($urandom_range(0, 3));
      end
      period = W'($urandom_range(0, 14));
      mode   = 1'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        case ($urandom_range(0, 4))
          0:       duty[c] = '0;
          1:       duty[c] = period;
          2:       duty[c] = period + 1'b1;
          3:       duty[c] = 8'd255;
          default: duty[c] = W'($urandom_range(0, 16));
        endcase
      end
      do_load();
      n = int'($urandom_range(5, 40));
      for (int k = 0; k < n; k++) begin
        en   = ($urandom_range(0, 15) != 0);
        load = ($urandom_range(0, 9) == 0);
        cyc(1);
      end
      en = 1'b1; load = 1'b0;
    end

    cyc(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
